// File: rtl/sram_pkg.sv
// Shared definitions for the multi-channel SRAM controller.
// Contents: controller state encoding and the default parameter values
// used by sram_mc_ctrl and its arbiter.
package sram_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 8;
  localparam int DEF_NUM_CH = 2;
  localparam int DEF_RD_LAT = 1;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with a registered last-granted pointer.
// Ports:
//   clk  - clock
//   rst  - asynchronous active-low reset (pointer -> N-1, so channel 0 wins first)
//   en   - arbitration enable; when low no grant is issued and the pointer holds
//   req  - per-requester request vector
//   gnt  - one-hot grant, combinational from req and the pointer
//   upd  - high when a grant is issued; the pointer moves to the winner on this edge
module rr_arbiter
  import sram_pkg::*;
#(
  parameter int N = DEF_NUM_CH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt,
  output logic         upd
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] nxt_ptr;
  logic [PW-1:0] idx;

  // Search starts one past the last winner and wraps; the first requester found wins.
  always_comb begin
    gnt     = '0;
    upd     = 1'b0;
    nxt_ptr = ptr;
    idx     = '0;
    for (int k = 1; k <= N; k++) begin
      idx = PW'((int'(ptr) + k) % N);
      if (en && !upd && req[idx]) begin
        gnt[idx] = 1'b1;
        upd      = 1'b1;
        nxt_ptr  = idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= PW'(N - 1);
    end else if (upd) begin
      ptr <= nxt_ptr;
    end
  end

endmodule

// File: rtl/sram_mc_ctrl.sv
// Multi-channel SRAM controller: clears the memory after reset, then
// arbitrates single-word read/write requests from NUM_CH channels
// round-robin, returning read data through an RD_LAT-deep pipeline.
//
// state   | meaning
// ST_INIT | sweeping every address, writing 0; no grants, ready low
// ST_RUN  | normal operation; requests arbitrated, ready high
//
// Ports:
//   clk    - clock
//   rst    - asynchronous active-low reset
//   wr, rd - per-channel write / read requests (both high = write, flags err)
//   addr   - per-channel address, channel i at [i*ADDR_W +: ADDR_W]
//   wdata  - per-channel write data, channel i at [i*DATA_W +: DATA_W]
//   gnt    - one-hot grant; request accepted on the edge where gnt[i] is high
//   rvalid - one-hot read-data valid, RD_LAT cycles after a read grant
//   rdata  - shared read data, holds its last value between reads
//   ready  - initialisation finished
//   err    - sticky flag: some channel asserted wr and rd together
module sram_mc_ctrl
  import sram_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int RD_LAT = DEF_RD_LAT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        wr,
  input  logic [NUM_CH-1:0]        rd,
  input  logic [NUM_CH*ADDR_W-1:0] addr,
  input  logic [NUM_CH*DATA_W-1:0] wdata,
  output logic [NUM_CH-1:0]        gnt,
  output logic [NUM_CH-1:0]        rvalid,
  output logic [DATA_W-1:0]        rdata,
  output logic                     ready,
  output logic                     err
);

  localparam int DEPTH = 2 ** ADDR_W;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] init_cnt;
  logic [ADDR_W-1:0] cnt_nxt;
  logic              init_we;

  logic              acc;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_wr;
  logic              sel_rd;
  logic              do_wr;
  logic              do_rd;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [NUM_CH-1:0] pv [RD_LAT];
  logic [DATA_W-1:0] pd [RD_LAT];

  // ---------------- state machine ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_INIT;
      init_cnt <= '0;
    end else begin
      state    <= state_nxt;
      init_cnt <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = init_cnt;
    init_we   = 1'b0;
    case (state)
      ST_INIT: begin
        init_we = 1'b1;
        cnt_nxt = init_cnt + ADDR_W'(1);
        if (init_cnt == {ADDR_W{1'b1}}) begin
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        state_nxt = ST_RUN;
      end
      default: begin
        state_nxt = ST_INIT;
      end
    endcase
  end

  assign ready = (state == ST_RUN);

  // ---------------- arbitration ----------------
  rr_arbiter #(
    .N (NUM_CH)
  ) u_arb (
    .clk (clk),
    .rst (rst),
    .en  (ready),
    .req (wr | rd),
    .gnt (gnt),
    .upd (acc)
  );

  // gnt is one-hot, so a plain priority loop acts as an AND-OR mux.
  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_wr    = 1'b0;
    sel_rd    = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (gnt[i]) begin
        sel_addr  = addr[i*ADDR_W +: ADDR_W];
        sel_wdata = wdata[i*DATA_W +: DATA_W];
        sel_wr    = wr[i];
        sel_rd    = rd[i];
      end
    end
  end

  // A combined wr+rd request is served as a write only.
  assign do_wr = acc & sel_wr;
  assign do_rd = acc & sel_rd & ~sel_wr;

  // ---------------- storage (no reset; cleared by the INIT sweep) ----------------
  always_ff @(posedge clk) begin
    if (init_we) begin
      mem[init_cnt] <= '0;
    end else if (do_wr) begin
      mem[sel_addr] <= sel_wdata;
    end
  end

  // ---------------- read pipeline ----------------
  // Data registers only load alongside a valid, so the last stage holds
  // the previous read result while rvalid is idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < RD_LAT; s++) begin
        pv[s] <= '0;
        pd[s] <= '0;
      end
    end else begin
      pv[0] <= do_rd ? gnt : '0;
      if (do_rd) begin
        pd[0] <= mem[sel_addr];
      end
      for (int s = 1; s < RD_LAT; s++) begin
        pv[s] <= pv[s-1];
        if (|pv[s-1]) begin
          pd[s] <= pd[s-1];
        end
      end
    end
  end

  assign rvalid = pv[RD_LAT-1];
  assign rdata  = pd[RD_LAT-1];

  // ---------------- error flag ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err <= 1'b0;
    end else if (|(wr & rd)) begin
      err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sram_mc_ctrl.sv
// Directed bench for sram_mc_ctrl. Three instances share one stimulus set:
//   u_a: ADDR_W=4, RD_LAT=1   u_b: ADDR_W=5, RD_LAT=2   u_c: ADDR_W=4, RD_LAT=3
// Inputs change 1 time unit after the rising edge; outputs are sampled on the
// falling edge.
module tb_sram_mc_ctrl;

  logic        clk;
  logic        rst;
  logic [1:0]  wr;
  logic [1:0]  rd;
  logic [9:0]  addr;
  logic [15:0] wdata;
  logic [7:0]  addr_s;

  logic [1:0] gnt_a, gnt_b, gnt_c;
  logic [1:0] rvalid_a, rvalid_b, rvalid_c;
  logic [7:0] rdata_a, rdata_b, rdata_c;
  logic       ready_a, ready_b, ready_c;
  logic       err_a, err_b, err_c;

  int checks;
  int failures;

  localparam logic [7:0] VALS [4] = '{8'h5A, 8'hC3, 8'h0F, 8'hE1};
  localparam logic [1:0] CHM  [4] = '{2'b01, 2'b01, 2'b10, 2'b10};
  localparam logic [1:0] ALT  [4] = '{2'b01, 2'b10, 2'b01, 2'b10};

  assign addr_s = {addr[8:5], addr[3:0]};

  sram_mc_ctrl #(.DATA_W(8), .ADDR_W(4), .NUM_CH(2), .RD_LAT(1)) u_a (
    .clk(clk), .rst(rst), .wr(wr), .rd(rd), .addr(addr_s), .wdata(wdata),
    .gnt(gnt_a), .rvalid(rvalid_a), .rdata(rdata_a), .ready(ready_a), .err(err_a)
  );

  sram_mc_ctrl #(.DATA_W(8), .ADDR_W(5), .NUM_CH(2), .RD_LAT(2)) u_b (
    .clk(clk), .rst(rst), .wr(wr), .rd(rd), .addr(addr), .wdata(wdata),
    .gnt(gnt_b), .rvalid(rvalid_b), .rdata(rdata_b), .ready(ready_b), .err(err_b)
  );

  sram_mc_ctrl #(.DATA_W(8), .ADDR_W(4), .NUM_CH(2), .RD_LAT(3)) u_c (
    .clk(clk), .rst(rst), .wr(wr), .rd(rd), .addr(addr_s), .wdata(wdata),
    .gnt(gnt_c), .rvalid(rvalid_c), .rdata(rdata_c), .ready(ready_c), .err(err_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // INIT sweep after a reset release made on a falling edge.
  task automatic run_init(input string tag);
    for (int n = 1; n <= 32; n++) begin
      @(posedge clk); #1;
      rd = (n <= 10) ? 2'b11 : 2'b00;
      @(negedge clk);
      checks++; if (ready_a !== 1'(n >= 16)) begin failures++; $display("FAIL %s ready_a n=%0d: got %b expected %b", tag, n, ready_a, 1'(n >= 16)); end
      checks++; if (ready_c !== 1'(n >= 16)) begin failures++; $display("FAIL %s ready_c n=%0d: got %b expected %b", tag, n, ready_c, 1'(n >= 16)); end
      checks++; if (ready_b !== 1'(n >= 32)) begin failures++; $display("FAIL %s ready_b n=%0d: got %b expected %b", tag, n, ready_b, 1'(n >= 32)); end
      checks++; if ({rvalid_a, rvalid_b, rvalid_c} !== 6'b0) begin failures++; $display("FAIL %s rvalid n=%0d: got %b expected 0", tag, n, {rvalid_a, rvalid_b, rvalid_c}); end
      checks++; if ({err_a, err_b, err_c} !== 3'b0) begin failures++; $display("FAIL %s err n=%0d: got %b expected 0", tag, n, {err_a, err_b, err_c}); end
      if (n <= 10) begin
        checks++; if ({gnt_a, gnt_b, gnt_c} !== 6'b0) begin failures++; $display("FAIL %s init_gnt n=%0d: got %b expected 0", tag, n, {gnt_a, gnt_b, gnt_c}); end
      end
    end
  endtask

  task automatic test_reset();
    wr = 2'b00; rd = 2'b00; addr = '0; wdata = '0;
    rst = 1'b1;
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if ({ready_a, ready_b, ready_c} !== 3'b0) begin failures++; $display("FAIL rst_ready: got %b expected 000", {ready_a, ready_b, ready_c}); end
    checks++; if ({rvalid_a, rvalid_b, rvalid_c} !== 6'b0) begin failures++; $display("FAIL rst_rvalid: got %b expected 0", {rvalid_a, rvalid_b, rvalid_c}); end
    checks++; if ({rdata_a, rdata_b, rdata_c} !== 24'h0) begin failures++; $display("FAIL rst_rdata: got %h expected 0", {rdata_a, rdata_b, rdata_c}); end
    checks++; if ({err_a, err_b, err_c} !== 3'b0) begin failures++; $display("FAIL rst_err: got %b expected 000", {err_a, err_b, err_c}); end
    checks++; if ({gnt_a, gnt_b, gnt_c} !== 6'b0) begin failures++; $display("FAIL rst_gnt: got %b expected 0", {gnt_a, gnt_b, gnt_c}); end
    rst = 1'b1;
    run_init("init");
  endtask

  task automatic test_alternate();
    @(posedge clk); #1;
    wr = 2'b00; rd = 2'b11; addr = '0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++; if (gnt_b !== ALT[k]) begin failures++; $display("FAIL alt_gnt_b k=%0d: got %b expected %b", k, gnt_b, ALT[k]); end
      checks++; if (gnt_a !== ALT[k]) begin failures++; $display("FAIL alt_gnt_a k=%0d: got %b expected %b", k, gnt_a, ALT[k]); end
      @(posedge clk); #1;
    end
    rd = 2'b00;
  endtask

  task automatic test_write_read();
    wr = 2'b01; rd = 2'b00; addr[4:0] = 5'h10; wdata[7:0] = 8'hA5;
    @(negedge clk);
    checks++; if (gnt_b !== 2'b01) begin failures++; $display("FAIL wr_gnt: got %b expected 01", gnt_b); end
    @(posedge clk); #1;
    wr = 2'b00; rd = 2'b01;
    @(negedge clk);
    checks++; if (gnt_b !== 2'b01) begin failures++; $display("FAIL rd_gnt: got %b expected 01", gnt_b); end
    @(posedge clk); #1;
    rd = 2'b00;
    @(negedge clk);
    checks++; if (rvalid_b !== 2'b00) begin failures++; $display("FAIL lat2_early: got %b expected 00", rvalid_b); end
    @(negedge clk);
    checks++; if (rvalid_b !== 2'b01) begin failures++; $display("FAIL lat2_rvalid: got %b expected 01", rvalid_b); end
    checks++; if (rdata_b !== 8'hA5) begin failures++; $display("FAIL lat2_rdata: got %h expected a5", rdata_b); end
    @(negedge clk);
    checks++; if (rvalid_b !== 2'b00) begin failures++; $display("FAIL lat2_pulse: got %b expected 00", rvalid_b); end
    checks++; if (rdata_b !== 8'hA5) begin failures++; $display("FAIL rdata_hold: got %h expected a5", rdata_b); end
  endtask

  task automatic test_err();
    @(posedge clk); #1;
    wr = 2'b10; rd = 2'b10; addr[9:5] = 5'h03; wdata[15:8] = 8'h3C;
    @(negedge clk);
    checks++; if (gnt_b !== 2'b10) begin failures++; $display("FAIL err_gnt: got %b expected 10", gnt_b); end
    checks++; if (err_b !== 1'b0) begin failures++; $display("FAIL err_early: got %b expected 0", err_b); end
    @(posedge clk); #1;
    wr = 2'b00; rd = 2'b00;
    @(negedge clk);
    checks++; if (err_b !== 1'b1) begin failures++; $display("FAIL err_set: got %b expected 1", err_b); end
    @(posedge clk); #1;
    rd = 2'b10;
    @(negedge clk);
    checks++; if (rvalid_b !== 2'b00) begin failures++; $display("FAIL err_no_read: got %b expected 00", rvalid_b); end
    checks++; if (gnt_b !== 2'b10) begin failures++; $display("FAIL err_rd_gnt: got %b expected 10", gnt_b); end
    @(posedge clk); #1;
    rd = 2'b00;
    @(negedge clk);
    checks++; if (rvalid_b !== 2'b00) begin failures++; $display("FAIL err_rd_early: got %b expected 00", rvalid_b); end
    @(negedge clk);
    checks++; if (rvalid_b !== 2'b10) begin failures++; $display("FAIL err_rd_rvalid: got %b expected 10", rvalid_b); end
    checks++; if (rdata_b !== 8'h3C) begin failures++; $display("FAIL err_rd_rdata: got %h expected 3c", rdata_b); end
    checks++; if (err_b !== 1'b1) begin failures++; $display("FAIL err_sticky: got %b expected 1", err_b); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      wr = 2'b01; rd = 2'b00; addr[4:0] = 5'(4 + i); wdata[7:0] = VALS[i];
      @(negedge clk);
      checks++; if (gnt_a !== 2'b01) begin failures++; $display("FAIL b2b_wr_gnt i=%0d: got %b expected 01", i, gnt_a); end
    end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      wr = 2'b00; rd = CHM[i];
      if (CHM[i][0]) addr[4:0] = 5'(4 + i);
      else           addr[9:5] = 5'(4 + i);
      @(negedge clk);
      checks++; if (gnt_a !== CHM[i]) begin failures++; $display("FAIL b2b_rd_gnt i=%0d: got %b expected %b", i, gnt_a, CHM[i]); end
      if (i > 0) begin
        checks++; if (rvalid_a !== CHM[i-1]) begin failures++; $display("FAIL b2b_rvalid i=%0d: got %b expected %b", i - 1, rvalid_a, CHM[i-1]); end
        checks++; if (rdata_a !== VALS[i-1]) begin failures++; $display("FAIL b2b_rdata i=%0d: got %h expected %h", i - 1, rdata_a, VALS[i-1]); end
      end
    end
    @(posedge clk); #1;
    rd = 2'b00;
    @(negedge clk);
    checks++; if (rvalid_a !== CHM[3]) begin failures++; $display("FAIL b2b_rvalid i=3: got %b expected %b", rvalid_a, CHM[3]); end
    checks++; if (rdata_a !== VALS[3]) begin failures++; $display("FAIL b2b_rdata i=3: got %h expected %h", rdata_a, VALS[3]); end
    @(negedge clk);
    checks++; if (rvalid_a !== 2'b00) begin failures++; $display("FAIL b2b_idle: got %b expected 00", rvalid_a); end
    checks++; if (rdata_a !== VALS[3]) begin failures++; $display("FAIL b2b_hold: got %h expected %h", rdata_a, VALS[3]); end
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    wr = 2'b00; rd = 2'b01; addr[4:0] = 5'h02;
    @(negedge clk);
    checks++; if (gnt_c !== 2'b01) begin failures++; $display("FAIL mid_gnt: got %b expected 01", gnt_c); end
    @(posedge clk); #1;
    rd = 2'b00;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++; if (rvalid_c !== 2'b00) begin failures++; $display("FAIL mid_rvalid: got %b expected 00", rvalid_c); end
    checks++; if (ready_c !== 1'b0) begin failures++; $display("FAIL mid_ready: got %b expected 0", ready_c); end
    checks++; if (rdata_c !== 8'h00) begin failures++; $display("FAIL mid_rdata: got %h expected 00", rdata_c); end
    checks++; if (err_b !== 1'b0) begin failures++; $display("FAIL mid_err: got %b expected 0", err_b); end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    run_init("reinit");
  endtask

  task automatic test_init_zero();
    for (int a = 0; a < 16; a++) begin
      @(posedge clk); #1;
      wr = 2'b00; rd = 2'b01; addr[4:0] = 5'(a);
      @(negedge clk);
      checks++; if (gnt_a !== 2'b01) begin failures++; $display("FAIL zero_gnt a=%0d: got %b expected 01", a, gnt_a); end
      if (a > 0) begin
        checks++; if (rvalid_a !== 2'b01) begin failures++; $display("FAIL zero_rvalid a=%0d: got %b expected 01", a - 1, rvalid_a); end
        checks++; if (rdata_a !== 8'h00) begin failures++; $display("FAIL zero_rdata a=%0d: got %h expected 00", a - 1, rdata_a); end
      end
    end
    @(posedge clk); #1;
    rd = 2'b00;
    @(negedge clk);
    checks++; if (rvalid_a !== 2'b01) begin failures++; $display("FAIL zero_rvalid a=15: got %b expected 01", rvalid_a); end
    checks++; if (rdata_a !== 8'h00) begin failures++; $display("FAIL zero_rdata a=15: got %h expected 00", rdata_a); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_alternate();
    test_write_read();
    test_err();
    test_back_to_back();
    test_reset_mid();
    test_init_zero();
    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
